eth_ctl_seq: RTL

Control-port sequencer for the ethernet100 RMII MAC. It owns the MAC's 3-bit I/O register bus and issues every access the MAC needs: PHY enable, transmit start, status polling and receive-buffer release. It arbitrates these between a local transmit requester, a local receive consumer and a free-running poll timer. It sits between ethernet100 and the frame-level logic that fills the transmit block RAM and drains the receive block RAM.

---
 rtl/eth_ctl_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/eth_ctl_seq.sv
// eth_ctl_seq: sequencer for the ethernet100 MAC I/O register bus.
// Arbitrates PHY-enable writes, receive-buffer release, transmit start and
// status polling. Every access is followed by a one-cycle gap.
module eth_ctl_seq #(
    parameter int unsigned POLL_INT = 64,
    parameter int unsigned TX_HOLD  = 16,
    parameter int unsigned LEN_W    = 11
) (
    input  logic             mclk,
    input  logic             mrst,
    input  logic             phy_en,
    input  logic             tx_req,
    input  logic [LEN_W-1:0] tx_len,
    output logic             tx_ack,
    output logic             tx_busy,
    output logic             rx_rdy,
    output logic [LEN_W-1:0] rx_len,
    output logic             rx_err,
    input  logic             rx_done,
    output logic             iocs,
    output logic             iowr,
    output logic             iord,
    output logic [2:0]       ioaddr,
    output logic [15:0]      iodo,
    input  logic [15:0]      iodi
);

    localparam int unsigned PW = $clog2(POLL_INT + 1);
    localparam int unsigned HW = $clog2(TX_HOLD + 1);

    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_CAP  = 3'd4;
    localparam logic [2:0] S_GAP  = 3'd5;

    logic [2:0]       r_state;
    logic             r_iocs, r_iowr, r_iord, r_tx_ack;
    logic [2:0]       r_ioaddr;
    logic [15:0]      r_iodo;
    logic             r_tx_busy, r_rx_rdy, r_rx_err;
    logic [LEN_W-1:0] r_rx_len;
    logic             r_phy_last, r_phy_pend, r_rel_pend;
    logic             r_rr;     // 1: poll has priority over tx start next time
    logic [PW-1:0]    r_poll_cnt;
    logic [HW-1:0]    r_hold;

    logic w_phy_pend, w_tx_pend, w_hold_done, w_poll_pend;
    logic w_sel_phy, w_sel_rel, w_sel_tx, w_sel_poll;

    // Job selection in IDLE: PHY write, release, then round-robin tx/poll.
    always_comb begin
        w_phy_pend  = r_phy_pend || (phy_en != r_phy_last);
        w_tx_pend   = tx_req && !r_tx_busy;
        w_hold_done = (r_hold == '0);
        // Polling is forced once the hold window has passed on a busy transmitter.
        w_poll_pend = (r_poll_cnt == '0) || (r_tx_busy && w_hold_done);
        w_sel_phy   = w_phy_pend;
        w_sel_rel   = !w_phy_pend && r_rel_pend;
        w_sel_tx    = !w_phy_pend && !r_rel_pend && w_tx_pend && (!w_poll_pend || !r_rr);
        w_sel_poll  = !w_phy_pend && !r_rel_pend && w_poll_pend && (!w_tx_pend || r_rr);
    end

    // Sequencer state, bus strobes, timers and status flags.
    always_ff @(posedge mclk) begin
        if (mrst) begin
            r_state    <= S_INIT;
            r_iocs     <= 1'b0;
            r_iowr     <= 1'b0;
            r_iord     <= 1'b0;
            r_tx_ack   <= 1'b0;
            r_ioaddr   <= 3'd0;
            r_iodo     <= 16'd0;
            r_tx_busy  <= 1'b0;
            r_rx_rdy   <= 1'b0;
            r_rx_err   <= 1'b0;
            r_rx_len   <= '0;
            r_phy_last <= 1'b0;
            r_phy_pend <= 1'b0;
            r_rel_pend <= 1'b0;
            r_rr       <= 1'b0;
            r_poll_cnt <= PW'(POLL_INT);
            r_hold     <= '0;
        end else begin
            r_iocs   <= 1'b0;
            r_iowr   <= 1'b0;
            r_iord   <= 1'b0;
            r_tx_ack <= 1'b0;
            if (r_poll_cnt != '0) r_poll_cnt <= r_poll_cnt - 1'b1;
            if (r_hold != '0)     r_hold     <= r_hold - 1'b1;
            // Consumer finished with the frame: drop rx_rdy, owe the MAC a release.
            if (rx_done && r_rx_rdy) begin
                r_rx_rdy   <= 1'b0;
                r_rel_pend <= 1'b1;
            end
            case (r_state)
                S_INIT: begin
                    r_phy_pend <= 1'b1;
                    r_state    <= S_IDLE;
                end
                S_IDLE: begin
                    if (w_sel_phy) begin
                        r_state    <= S_WR;
                        r_iocs     <= 1'b1;
                        r_iowr     <= 1'b1;
                        r_ioaddr   <= 3'd3;
                        r_iodo     <= {15'd0, phy_en};
                        r_phy_last <= phy_en;
                        r_phy_pend <= 1'b0;
                    end else if (w_sel_rel) begin
                        r_state    <= S_WR;
                        r_iocs     <= 1'b1;
                        r_iowr     <= 1'b1;
                        r_ioaddr   <= 3'd0;
                        r_iodo     <= 16'd0;
                        r_rel_pend <= 1'b0;
                    end else if (w_sel_tx) begin
                        r_state   <= S_WR;
                        r_iocs    <= 1'b1;
                        r_iowr    <= 1'b1;
                        r_ioaddr  <= 3'd1;
                        r_iodo    <= 16'(tx_len);
                        r_tx_ack  <= 1'b1;
                        r_tx_busy <= 1'b1;
                        r_hold    <= HW'(TX_HOLD);
                        r_rr      <= 1'b1;
                    end else if (w_sel_poll) begin
                        r_state  <= S_RD;
                        r_iocs   <= 1'b1;
                        r_iord   <= 1'b1;
                        r_ioaddr <= 3'd0;
                        r_iodo   <= 16'd0;
                        r_rr     <= 1'b0;
                    end
                end
                S_WR: r_state <= S_GAP;
                S_RD: r_state <= S_CAP;
                S_CAP: begin
                    // A frame still awaiting its release write must not be recaptured.
                    if (!r_rx_rdy && !r_rel_pend && iodi[15]) begin
                        r_rx_rdy <= 1'b1;
                        r_rx_err <= iodi[14];
                        r_rx_len <= iodi[LEN_W-1:0];
                    end
                    if (!iodi[13] && w_hold_done) r_tx_busy <= 1'b0;
                    r_poll_cnt <= PW'(POLL_INT);
                    r_state    <= S_GAP;
                end
                S_GAP:   r_state <= S_IDLE;
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign iocs    = r_iocs;
    assign iowr    = r_iowr;
    assign iord    = r_iord;
    assign ioaddr  = r_ioaddr;
    assign iodo    = r_iodo;
    assign tx_ack  = r_tx_ack;
    assign tx_busy = r_tx_busy;
    assign rx_rdy  = r_rx_rdy;
    assign rx_len  = r_rx_len;
    assign rx_err  = r_rx_err;

endmodule
